store_wbuf: RTL and testbench
=============================

Name: store_wbuf

Overview:
- Store-side responder for the control/decode stage's store requests (sd and narrower stores, carrying an 8-bit byte-lane wmask).
- Accepts stores from the core into a small in-order FIFO and drains them to the data-memory write port over a valid/ready handshake.
- Checks each load address against pending stores so loads never read stale memory.
- Sits between the execute stage and the pmem write interface.

Parameters:
DEPTH, 4, number of buffered store entries (power of 2, >=2)
ADDR_W, 64, address width (CPU_WIDTH)
DATA_W, 64, data width (CPU_WIDTH); MASK_W = DATA_W/8 = 8

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
st_valid  input  1  core presents a store
st_ready  output  1  buffer can accept a store this cycle
st_addr  input  ADDR_W  store byte address; low 3 bits ignored
st_wdata  input  DATA_W  store data, already lane-aligned
st_wmask  input  MASK_W  byte-lane write mask
mem_wvalid  output  1  head entry presented to memory
mem_wready  input  1  memory accepts the head entry
mem_waddr  output  ADDR_W  {head_addr[ADDR_W-1:3],3'b000}
mem_wdata  output  DATA_W  head entry data
mem_wmask  output  MASK_W  head entry mask
ld_valid  input  1  load address valid this cycle
ld_addr  input  ADDR_W  load byte address
ld_stall  output  1  load must wait (pending conflicting store)
ld_fwd_data  output  DATA_W  forwarded bytes (feature only, else 0)
ld_fwd_mask  output  MASK_W  lanes covered by forwarding (feature only, else 0)
empty  output  1  no pending entries
count  output  $clog2(DEPTH)+1  number of pending entries

Behaviour:
- Reset (rst_n low, asynchronous):
  - head/tail pointers, count and all entry valid bits cleared.
  - Outputs: mem_wvalid=0, mem_waddr/wdata/wmask=0, st_ready=1, empty=1, ld_stall=0, ld_fwd_*=0.
  - Reset mid-drain discards all entries, including a head that is presented but not yet accepted.
- Push:
  - Occurs when st_valid && st_ready at a rising edge. The entry is written at tail and tail increments mod DEPTH.
  - st_ready = (count != DEPTH). It is combinational and does not depend on a same-cycle pop: a full buffer refuses a store even if the head drains that cycle.
  - A store with st_wmask == 0 is handshaken (st_ready honoured) but not enqueued; count is unchanged.
- Drain:
  - mem_wvalid = (count != 0). mem_w* are driven from the head entry storage.
  - The head must hold stable while mem_wvalid && !mem_wready.
  - Pop occurs when mem_wvalid && mem_wready. Head increments mod DEPTH.
  - Store-to-memory latency is at least 1 cycle: a store pushed at edge N can appear on mem_w* in cycle N+1 at the earliest.
- Simultaneous push and pop: both take effect and count is unchanged.
  - At count==1, the pushed entry becomes head on the next cycle.
  - At count==DEPTH, only the pop occurs.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count disambiguates full vs empty.
- Conflict check (combinational, same cycle as ld_valid):
  - An entry matches when valid && addr[ADDR_W-1:3] == ld_addr[ADDR_W-1:3] && (entry mask != 0).
  - The check sees entries as of the current cycle. A store being pushed in the same cycle is not checked; the core guarantees no same-cycle store/load pair.
  - ld_stall=0 whenever ld_valid=0.
- empty = (count==0). count is registered.

Optional Feature:
Macro WBUF_FWD_EN.
- Defined:
  - Store-to-load forwarding is enabled. For each byte lane, the youngest matching entry supplies ld_fwd_data lane and sets ld_fwd_mask bit.
  - ld_stall = 0; the load merges forwarded lanes over memory data.
- Undefined:
  - No forwarding logic. ld_fwd_data=0 and ld_fwd_mask=0.
  - ld_stall = ld_valid && (any entry matches). The core retries until drained.

Test Plan:
- Reset then push st_addr=0x80000010, wdata=0x1122334455667788, wmask=0xFF with mem_wready=1 -> next cycle mem_wvalid=1, mem_waddr=0x80000010, wdata/wmask match; count returns 0 after handshake.
- mem_wready=0, push 4 stores -> count=4, st_ready=0, 5th store not accepted. Raise mem_wready -> entries drain in push order, one per cycle.
- At count=2, assert st_valid and mem_wready in the same cycle -> count stays 2, head advances, tail advances, order preserved across pointer wrap.
- Push wmask=0x00 -> handshake completes, count stays 0, mem_wvalid stays 0.
- Buffer 0x80000008 mask 0x0F data 0xAAAAAAAA and a younger entry at 0x8000000C mask 0x03 data 0xBBBB; ld_addr=0x80000008:
  - With WBUF_FWD_EN: ld_fwd_mask=0x0F, ld_fwd_data=0x00000000AAAABBBB, ld_stall=0.
  - Without WBUF_FWD_EN: ld_stall=1 until both entries are drained.
- rst_n low with 3 entries pending and mem_wready=0 -> mem_wvalid=0 and empty=1 immediately (asynchronous). Subsequent push works normally.

Source files
------------

// File: rtl/store_wbuf_if.sv
//------------------------------------------------------------------------------
// Module   : store_wbuf_if
// Purpose  : Bundles the three buses around the store write buffer: the
//            core store request, the data-memory write port and the load
//            conflict/forwarding query, plus the occupancy status.
// Modports : slave  - the write buffer itself
//            master - whoever drives the core side and the memory side
// Ports    : st_valid/st_ready/st_addr/st_wdata/st_wmask   core store request
//            mem_wvalid/mem_wready/mem_waddr/mem_wdata/mem_wmask  memory write
//            ld_valid/ld_addr/ld_stall/ld_fwd_data/ld_fwd_mask    load query
//            empty/count                                   occupancy status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface store_wbuf_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_wdata;
  logic [MASK_W-1:0] st_wmask;

  logic              mem_wvalid;
  logic              mem_wready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_stall;
  logic [DATA_W-1:0] ld_fwd_data;
  logic [MASK_W-1:0] ld_fwd_mask;

  logic              empty;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_wmask,
    output st_ready,
    output mem_wvalid, mem_waddr, mem_wdata, mem_wmask,
    input  mem_wready,
    input  ld_valid, ld_addr,
    output ld_stall, ld_fwd_data, ld_fwd_mask,
    output empty, count
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_wmask,
    input  st_ready,
    input  mem_wvalid, mem_waddr, mem_wdata, mem_wmask,
    output mem_wready,
    output ld_valid, ld_addr,
    input  ld_stall, ld_fwd_data, ld_fwd_mask,
    input  empty, count
  );

endinterface

`default_nettype wire

// File: rtl/store_wbuf.sv
//------------------------------------------------------------------------------
// Module   : store_wbuf
// Purpose  : In-order store write buffer. Accepts byte-masked stores from the
//            core, drains them one at a time to the data-memory write port and
//            answers same-cycle load address queries against pending stores.
// Config   : `define WBUF_FWD_EN enables store-to-load forwarding (youngest
//            matching entry per byte lane, never stalls). Without it, a load
//            that hits any pending store in the same 8-byte line is stalled.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - store_wbuf_if.slave (store, memory write, load query,
//                     empty/count status)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  store_wbuf_if.slave  bus
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  // Keeps the 8-byte line part of an address; the low 3 bits select a lane.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(7));

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [MASK_W-1:0] ent_mask [DEPTH];
  logic [DEPTH-1:0]  ent_valid;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;

  logic              not_full;
  logic              head_valid;
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  match;

  // Ready depends only on the registered count, so a full buffer refuses a
  // store even in a cycle where the head drains.
  assign not_full   = (count_q != FULL_CNT);
  assign head_valid = (count_q != '0);

  // Zero-mask stores are handshaken but write nothing, so they are dropped.
  assign push = bus.st_valid && not_full && (bus.st_wmask != '0);
  assign pop  = head_valid && bus.mem_wready;

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ent_valid <= '0;
    end else begin
      // push and pop never target the same slot: that would need count==0
      // (no pop) or count==DEPTH (no push).
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload needs no reset: it is only observed through valid bits.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= bus.st_addr;
      ent_data[tail] <= bus.st_wdata;
      ent_mask[tail] <= bus.st_wmask;
    end
  end

  assign bus.st_ready   = not_full;
  assign bus.empty      = !head_valid;
  assign bus.count      = count_q;
  assign bus.mem_wvalid = head_valid;
  // Payload is forced to zero while idle so stale storage never leaks out.
  assign bus.mem_waddr  = head_valid ? (ent_addr[head] & LINE_MASK) : '0;
  assign bus.mem_wdata  = head_valid ? ent_data[head] : '0;
  assign bus.mem_wmask  = head_valid ? ent_mask[head] : '0;

  // Per-entry line match against the load address.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign match[g] = ent_valid[g]
                   && (((ent_addr[g] ^ bus.ld_addr) & LINE_MASK) == '0)
                   && (ent_mask[g] != '0);
  end

`ifdef WBUF_FWD_EN
  logic [DATA_W-1:0] fwd_data;
  logic [MASK_W-1:0] fwd_mask;
  logic [PTR_W-1:0]  idx;

  // Walk entries oldest to youngest so younger lanes overwrite older ones.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    idx      = '0;
    if (bus.ld_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PTR_W'(k);
        if (match[idx]) begin
          for (int b = 0; b < MASK_W; b++) begin
            if (ent_mask[idx][b]) begin
              fwd_data[8*b +: 8] = ent_data[idx][8*b +: 8];
              fwd_mask[b]        = 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.ld_stall    = 1'b0;
  assign bus.ld_fwd_data = fwd_data;
  assign bus.ld_fwd_mask = fwd_mask;
`else
  assign bus.ld_stall    = bus.ld_valid && (|match);
  assign bus.ld_fwd_data = '0;
  assign bus.ld_fwd_mask = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_wbuf.sv
//------------------------------------------------------------------------------
// Module   : tb_store_wbuf
// Purpose  : Self-checking bench for store_wbuf. A reference model keeps the
//            pending stores as a queue; a negedge monitor compares status,
//            memory-write payload and load-query answers against it.
// Config   : honours `define WBUF_FWD_EN for the expected load behaviour.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_store_wbuf;

  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } ent_t;

  logic clk;
  logic rst_n;

  store_wbuf_if #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) bus ();

  store_wbuf #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  ent_t exp_q[$];
  int   model_cnt = 0;
  bit   do_push;
  bit   do_pop;
  ent_t new_ent;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: FIFO of accepted stores, updated at the clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      do_pop  = bus.mem_wready && (model_cnt != 0);
      do_push = bus.st_valid && (model_cnt != DEPTH) && (bus.st_wmask != 8'h00);
      if (do_push) begin
        new_ent.addr = bus.st_addr;
        new_ent.data = bus.st_wdata;
        new_ent.mask = bus.st_wmask;
        exp_q.push_back(new_ent);
      end
      model_cnt = model_cnt + int'(do_push) - int'(do_pop);
    end
  end

  // Monitor: status, load query, then memory write compare/pop.
  logic [63:0] e_data;
  logic [7:0]  e_mask;
  bit          e_hit;
  ent_t        head_e;

  always @(negedge clk) begin
    chk("count", 64'(bus.count), 64'(model_cnt));
    chk("empty", 64'(bus.empty), 64'(model_cnt == 0));
    chk("st_ready", 64'(bus.st_ready), 64'(model_cnt != DEPTH));
    chk("mem_wvalid", 64'(bus.mem_wvalid), 64'(model_cnt != 0));

    if (bus.ld_valid) begin
      e_data = '0;
      e_mask = '0;
      e_hit  = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i].addr[63:3] == bus.ld_addr[63:3]) begin
          e_hit = 1'b1;
          for (int b = 0; b < 8; b++) begin
            if (exp_q[i].mask[b]) begin
              e_data[8*b +: 8] = exp_q[i].data[8*b +: 8];
              e_mask[b]        = 1'b1;
            end
          end
        end
      end
`ifdef WBUF_FWD_EN
      chk("ld_stall", 64'(bus.ld_stall), 64'd0);
      chk("ld_fwd_mask", 64'(bus.ld_fwd_mask), 64'(e_mask));
      chk("ld_fwd_data", bus.ld_fwd_data, e_data);
`else
      chk("ld_stall", 64'(bus.ld_stall), 64'(e_hit));
      chk("ld_fwd_mask", 64'(bus.ld_fwd_mask), 64'd0);
      chk("ld_fwd_data", bus.ld_fwd_data, 64'd0);
`endif
    end else begin
      chk("ld_stall_idle", 64'(bus.ld_stall), 64'd0);
    end

    if (bus.mem_wvalid) begin
      if (exp_q.size() == 0) begin
        chk("mem_wvalid_unexpected", 64'd1, 64'd0);
      end else begin
        head_e = exp_q[0];
        chk("mem_waddr", bus.mem_waddr, {head_e.addr[63:3], 3'b000});
        chk("mem_wdata", bus.mem_wdata, head_e.data);
        chk("mem_wmask", 64'(bus.mem_wmask), 64'(head_e.mask));
        if (bus.mem_wready) void'(exp_q.pop_front());
      end
    end else begin
      chk("mem_waddr_idle", bus.mem_waddr, 64'd0);
      chk("mem_wdata_idle", bus.mem_wdata, 64'd0);
      chk("mem_wmask_idle", 64'(bus.mem_wmask), 64'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] m);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_wdata = d;
    bus.st_wmask = m;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (model_cnt != 0 && n < max_cycles) begin
      cyc();
      n++;
    end
    if (model_cnt != 0) chk("drain_timeout", 64'(model_cnt), 64'd0);
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] a;
    a = 64'h8000_0000 + 64'(($urandom % 4) * 8) + 64'($urandom % 8);
    return a;
  endfunction

  function automatic logic [7:0] rnd_mask();
    logic [7:0] m;
    m = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
    return m;
  endfunction

  initial begin
    rst_n          = 1'b0;
    bus.mem_wready = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    set_store(1'b0, '0, '0, '0);
    repeat (2) cyc();
    chk("reset_st_ready", 64'(bus.st_ready), 64'd1);
    chk("reset_empty", 64'(bus.empty), 64'd1);
    rst_n = 1'b1;
    cyc();

    // Single store passes straight through.
    bus.mem_wready = 1'b1;
    set_store(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    cyc();
    set_store(1'b0, '0, '0, '0);
    chk("first_wvalid", 64'(bus.mem_wvalid), 64'd1);
    chk("first_waddr", bus.mem_waddr, 64'h8000_0010);
    cyc();
    chk("first_count_after", 64'(bus.count), 64'd0);

    // Fill to full with memory stalled; fifth store must be refused.
    bus.mem_wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_store(1'b1, 64'h8000_0100 + 64'(i * 8), 64'(64'hC0DE_0000 + i), 8'hFF);
      if (i == 4) chk("full_st_ready", 64'(bus.st_ready), 64'd0);
      cyc();
    end
    set_store(1'b0, '0, '0, '0);
    chk("full_count", 64'(bus.count), 64'd4);
    bus.mem_wready = 1'b1;
    wait_drain(20);

    // Simultaneous push/pop at count 2, running across pointer wrap.
    bus.mem_wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_store(1'b1, 64'h8000_0200 + 64'(i * 8), 64'($urandom), 8'hF0);
      cyc();
    end
    bus.mem_wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_store(1'b1, 64'h8000_0300 + 64'(i * 8), {32'($urandom), 32'($urandom)}, 8'($urandom | 1));
      cyc();
      chk("pushpop_count", 64'(bus.count), 64'd2);
    end
    set_store(1'b0, '0, '0, '0);
    wait_drain(20);

    // Zero-mask store: handshaken, never enqueued.
    set_store(1'b1, 64'h8000_0400, 64'hDEAD_BEEF, 8'h00);
    chk("zmask_ready", 64'(bus.st_ready), 64'd1);
    cyc();
    set_store(1'b0, '0, '0, '0);
    chk("zmask_count", 64'(bus.count), 64'd0);
    chk("zmask_wvalid", 64'(bus.mem_wvalid), 64'd0);

    // Overlapping stores in one line, then a load to that line.
    bus.mem_wready = 1'b0;
    set_store(1'b1, 64'h8000_0008, 64'h0000_0000_AAAA_AAAA, 8'h0F);
    cyc();
    set_store(1'b1, 64'h8000_000C, 64'h0000_0000_0000_BBBB, 8'h03);
    cyc();
    set_store(1'b0, '0, '0, '0);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 64'h8000_0008;
    #1;
`ifdef WBUF_FWD_EN
    chk("fwd_mask_dir", 64'(bus.ld_fwd_mask), 64'h0F);
    chk("fwd_data_dir", bus.ld_fwd_data, 64'h0000_0000_AAAA_BBBB);
    chk("fwd_stall_dir", 64'(bus.ld_stall), 64'd0);
`else
    chk("stall_dir", 64'(bus.ld_stall), 64'd1);
`endif
    cyc();
    bus.mem_wready = 1'b1;
    cyc();
`ifndef WBUF_FWD_EN
    chk("stall_one_left", 64'(bus.ld_stall), 64'd1);
`endif
    cyc();
    chk("stall_drained", 64'(bus.ld_stall), 64'd0);
    bus.ld_valid = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 2 == 1)
        set_store(1'b1, rnd_addr(), {32'($urandom), 32'($urandom)}, rnd_mask());
      else
        set_store(1'b0, '0, '0, '0);
      bus.mem_wready = ($urandom % 3 != 0);
      bus.ld_valid   = ($urandom % 2 == 1);
      bus.ld_addr    = rnd_addr();
      cyc();
    end
    set_store(1'b0, '0, '0, '0);
    bus.ld_valid   = 1'b0;
    bus.mem_wready = 1'b1;
    wait_drain(20);

    // Asynchronous reset with stores pending and memory stalled.
    bus.mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 64'h8000_0500 + 64'(i * 8), 64'($urandom), 8'hFF);
      cyc();
    end
    set_store(1'b0, '0, '0, '0);
    chk("pre_reset_count", 64'(bus.count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_wvalid", 64'(bus.mem_wvalid), 64'd0);
    chk("async_empty", 64'(bus.empty), 64'd1);
    chk("async_count", 64'(bus.count), 64'd0);
    cyc();
    rst_n = 1'b1;
    bus.mem_wready = 1'b1;
    set_store(1'b1, 64'h8000_0600, 64'h0123_4567_89AB_CDEF, 8'h3C);
    cyc();
    set_store(1'b0, '0, '0, '0);
    chk("post_reset_waddr", bus.mem_waddr, 64'h8000_0600);
    wait_drain(20);

    cyc();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
